// File: rtl/hazard_unit.sv
// Load-use / RAW hazard detection and EX forward-select generation for the 5-stage pipeline.
// stall is combinational from ID and shadow state; forwA/forwB register one cycle later.
module hazard_unit #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              isForw_ON,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              flush,
  output logic              stall,
  output logic [1:0]        forwA,
  output logic [1:0]        forwB,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  forw_events
);

  localparam logic [1:0]       SEL_RF    = 2'b00;
  localparam logic [1:0]       SEL_EXMEM = 2'b01;
  localparam logic [1:0]       SEL_MEMWB = 2'b10;
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  // A WB producer is already visible through the write-before-read register
  // file, so only EX and MEM destinations are shadowed; MEM needs no load flag.
  logic [REG_AW-1:0] ex_rd_q, ex_rd_d;
  logic              ex_wr_q, ex_wr_d;
  logic              ex_mr_q, ex_mr_d;
  logic [REG_AW-1:0] mem_rd_q;
  logic              mem_wr_q;

  logic [1:0]        forw_a_q, forw_a_d;
  logic [1:0]        forw_b_q, forw_b_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  forw_cnt_q, forw_cnt_d;

  logic ex_hit_rs1, ex_hit_rs2, mem_hit_rs1, mem_hit_rs2;
  logic match_ex, match_mem;
  logic stall_w, ex_load;

  always_comb begin
    ex_hit_rs1  = ex_wr_q  && (ex_rd_q  == id_rs1) && (id_rs1 != '0);
    ex_hit_rs2  = ex_wr_q  && (ex_rd_q  == id_rs2) && (id_rs2 != '0);
    mem_hit_rs1 = mem_wr_q && (mem_rd_q == id_rs1) && (id_rs1 != '0);
    mem_hit_rs2 = mem_wr_q && (mem_rd_q == id_rs2) && (id_rs2 != '0);
    match_ex    = (id_use_rs1 && ex_hit_rs1)  || (id_use_rs2 && ex_hit_rs2);
    match_mem   = (id_use_rs1 && mem_hit_rs1) || (id_use_rs2 && mem_hit_rs2);
  end

  // With forwarding on only a load in EX cannot be bypassed in time.
  always_comb begin
    stall_w = 1'b0;
    if (id_valid && !flush) begin
      if (isForw_ON) stall_w = match_ex && ex_mr_q;
      else           stall_w = match_ex || match_mem;
    end
  end

  assign ex_load = id_valid && !stall_w && !flush;

  always_comb begin
    forw_a_d = SEL_RF;
    forw_b_d = SEL_RF;
    if (ex_load && isForw_ON) begin
      if (id_use_rs1) begin
        if (ex_hit_rs1)       forw_a_d = SEL_EXMEM;
        else if (mem_hit_rs1) forw_a_d = SEL_MEMWB;
      end
      if (id_use_rs2) begin
        if (ex_hit_rs2)       forw_b_d = SEL_EXMEM;
        else if (mem_hit_rs2) forw_b_d = SEL_MEMWB;
      end
    end
  end

  always_comb begin
    ex_rd_d = '0;
    ex_wr_d = 1'b0;
    ex_mr_d = 1'b0;
    if (ex_load) begin
      ex_rd_d = id_rd;
      ex_wr_d = id_reg_write;
      ex_mr_d = id_mem_read;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    forw_cnt_d  = forw_cnt_q;
    if (stall_w && (stall_cnt_q != CNT_MAX))
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    if (ex_load && ((forw_a_d != SEL_RF) || (forw_b_d != SEL_RF)) && (forw_cnt_q != CNT_MAX))
      forw_cnt_d = forw_cnt_q + CNT_ONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_rd_q     <= '0;
      ex_wr_q     <= 1'b0;
      ex_mr_q     <= 1'b0;
      mem_rd_q    <= '0;
      mem_wr_q    <= 1'b0;
      forw_a_q    <= SEL_RF;
      forw_b_q    <= SEL_RF;
      stall_cnt_q <= '0;
      forw_cnt_q  <= '0;
    end else begin
      ex_rd_q     <= ex_rd_d;
      ex_wr_q     <= ex_wr_d;
      ex_mr_q     <= ex_mr_d;
      mem_rd_q    <= ex_rd_q;
      mem_wr_q    <= ex_wr_q;
      forw_a_q    <= forw_a_d;
      forw_b_q    <= forw_b_d;
      stall_cnt_q <= stall_cnt_d;
      forw_cnt_q  <= forw_cnt_d;
    end
  end

  assign stall        = stall_w;
  assign forwA        = forw_a_q;
  assign forwB        = forw_b_q;
  assign stall_cycles = stall_cnt_q;
  assign forw_events  = forw_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: directed instruction-sequence table, mid-stall reset,
// counter saturation, then random traffic against a pipeline-queue reference model.
module tb_hazard_unit;

  localparam int AW   = 5;
  localparam int CW   = 5;
  localparam int MAXC = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          isForw_ON, id_valid, id_use_rs1, id_use_rs2;
  logic [AW-1:0] id_rs1, id_rs2, id_rd;
  logic          id_reg_write, id_mem_read, flush;
  logic          stall;
  logic [1:0]    forwA, forwB;
  logic [CW-1:0] stall_cycles, forw_events;

  hazard_unit #(.REG_AW(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .isForw_ON(isForw_ON), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
    .stall(stall), .forwA(forwA), .forwB(forwB),
    .stall_cycles(stall_cycles), .forw_events(forw_events)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: in-flight instructions, index 0 = EX ----------------
  typedef struct {
    logic [AW-1:0] rd;
    logic          wr;
    logic          mr;
  } slot_t;

  slot_t    pipe [3];
  int       m_sc, m_fe;
  int       m_fa, m_fb;

  function automatic logic produces(input int i, input logic [AW-1:0] r);
    return pipe[i].wr && (pipe[i].rd == r) && (r != 0);
  endfunction

  function automatic logic m_match(input int i);
    return (id_use_rs1 && produces(i, id_rs1)) || (id_use_rs2 && produces(i, id_rs2));
  endfunction

  function automatic logic m_stall();
    if (!id_valid || flush) return 1'b0;
    if (isForw_ON) return m_match(0) && pipe[0].mr;
    return m_match(0) || m_match(1);
  endfunction

  function automatic int m_sel(input logic [AW-1:0] r, input logic use_r);
    if (!isForw_ON || !use_r) return 0;
    if (produces(0, r)) return 1;
    if (produces(1, r)) return 2;
    return 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) pipe[i] = '{rd: '0, wr: 1'b0, mr: 1'b0};
    m_sc = 0; m_fe = 0; m_fa = 0; m_fb = 0;
  endtask

  task automatic model_check();
    chk("stall",        int'(stall),        int'(m_stall()));
    chk("forwA",        int'(forwA),        m_fa);
    chk("forwB",        int'(forwB),        m_fb);
    chk("stall_cycles", int'(stall_cycles), m_sc);
    chk("forw_events",  int'(forw_events),  m_fe);
  endtask

  // Advance one clock; model commits with the inputs held across the edge.
  task automatic tick();
    logic  st, enter;
    int    fa, fb;
    slot_t nx;
    st    = m_stall();
    enter = id_valid && !st && !flush;
    fa    = enter ? m_sel(id_rs1, id_use_rs1) : 0;
    fb    = enter ? m_sel(id_rs2, id_use_rs2) : 0;
    nx    = enter ? '{rd: id_rd, wr: id_reg_write, mr: id_mem_read} : '{rd: '0, wr: 1'b0, mr: 1'b0};
    @(posedge clk);
    #1;
    if (st && m_sc < MAXC) m_sc++;
    if (enter && (fa != 0 || fb != 0) && m_fe < MAXC) m_fe++;
    m_fa = fa; m_fb = fb;
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    pipe[0] = nx;
  endtask

  task automatic set_in(input logic fon, input logic vld, input int rs1, input int rs2,
                        input logic u1, input logic u2, input int rd, input logic wr,
                        input logic mr, input logic fl);
    isForw_ON = fon; id_valid = vld;
    id_rs1 = AW'(rs1); id_rs2 = AW'(rs2); id_use_rs1 = u1; id_use_rs2 = u2;
    id_rd = AW'(rd); id_reg_write = wr; id_mem_read = mr; flush = fl;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic rst_before;
    logic fon, vld;
    int   rs1, rs2;
    logic u1, u2;
    int   rd;
    logic wr, mr, fl;
    int   e_stall, e_fa, e_fb, e_sc, e_fe;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic r, input logic fon, input logic vld,
                              input int rs1, input int rs2, input logic u1, input logic u2,
                              input int rd, input logic wr, input logic mr, input logic fl,
                              input int es, input int efa, input int efb, input int esc, input int efe);
    vec_t v;
    v = '{rst_before: r, fon: fon, vld: vld, rs1: rs1, rs2: rs2, u1: u1, u2: u2, rd: rd,
          wr: wr, mr: mr, fl: fl, e_stall: es, e_fa: efa, e_fb: efb, e_sc: esc, e_fe: efe};
    return v;
  endfunction

  function automatic vec_t nop(input logic fon, input int efa, input int efb, input int esc, input int efe);
    return mk(0, fon, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, efa, efb, esc, efe);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    set_in(1, 1, 1, 2, 1, 1, 5, 1, 0, 0);
    #1;
    chk("reset_stall", int'(stall), 0);
    chk("reset_forwA", int'(forwA), 0);
    chk("reset_forwB", int'(forwB), 0);
    chk("reset_sc",    int'(stall_cycles), 0);
    chk("reset_fe",    int'(forw_events), 0);
    rst = 1'b0;
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    // back-to-back producer/consumer: forwA=01
    vq.push_back(mk(1, 1, 1, 1, 2, 1, 1, 5, 1, 0, 0,  0, 0, 0, 0, 0));
    vq.push_back(mk(0, 1, 1, 5, 3, 1, 1, 6, 1, 0, 0,  0, 0, 0, 0, 0));
    vq.push_back(nop(1, 1, 0, 0, 1));
    vq.push_back(nop(1, 0, 0, 0, 1));
    // two producers of x5: EX wins over MEM on both operands
    vq.push_back(mk(1, 1, 1, 1, 2, 1, 1, 5, 1, 0, 0,  0, 0, 0, 0, 0));
    vq.push_back(mk(0, 1, 1, 3, 4, 1, 1, 5, 1, 0, 0,  0, 0, 0, 0, 0));
    vq.push_back(mk(0, 1, 1, 5, 5, 1, 1, 7, 1, 0, 0,  0, 0, 0, 0, 0));
    vq.push_back(nop(1, 1, 1, 0, 1));
    // producer two ahead: forwA=10
    vq.push_back(mk(1, 1, 1, 1, 2, 1, 1, 5, 1, 0, 0,  0, 0, 0, 0, 0));
    vq.push_back(nop(1, 0, 0, 0, 0));
    vq.push_back(mk(0, 1, 1, 5, 3, 1, 1, 6, 1, 0, 0,  0, 0, 0, 0, 0));
    vq.push_back(nop(1, 2, 0, 0, 1));
    // load-use: one stall, bubble, then forwB=10
    vq.push_back(mk(1, 1, 1, 1, 0, 1, 0, 5, 1, 1, 0,  0, 0, 0, 0, 0));
    vq.push_back(mk(0, 1, 1, 1, 5, 1, 1, 6, 1, 0, 0,  1, 0, 0, 0, 0));
    vq.push_back(mk(0, 1, 1, 1, 5, 1, 1, 6, 1, 0, 0,  0, 0, 0, 1, 0));
    vq.push_back(nop(1, 0, 2, 1, 1));
    // forwarding off: two stall cycles, selects stay 00
    vq.push_back(mk(1, 0, 1, 1, 2, 1, 1, 5, 1, 0, 0,  0, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 1, 5, 0, 1, 1, 6, 1, 0, 0,  1, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 1, 5, 0, 1, 1, 6, 1, 0, 0,  1, 0, 0, 1, 0));
    vq.push_back(mk(0, 0, 1, 5, 0, 1, 1, 6, 1, 0, 0,  0, 0, 0, 2, 0));
    vq.push_back(nop(0, 0, 0, 2, 0));
    // x0 never hazards; flush beats a load-use stall
    vq.push_back(mk(1, 1, 1, 1, 2, 1, 1, 0, 1, 0, 0,  0, 0, 0, 0, 0));
    vq.push_back(mk(0, 1, 1, 0, 0, 1, 1, 6, 1, 0, 0,  0, 0, 0, 0, 0));
    vq.push_back(nop(1, 0, 0, 0, 0));
    vq.push_back(mk(0, 1, 1, 1, 0, 1, 0, 5, 1, 1, 0,  0, 0, 0, 0, 0));
    vq.push_back(mk(0, 1, 1, 5, 1, 1, 1, 6, 1, 0, 1,  0, 0, 0, 0, 0));
    vq.push_back(nop(1, 0, 0, 0, 0));

    foreach (vq[i]) begin
      if (vq[i].rst_before) pulse_reset();
      set_in(vq[i].fon, vq[i].vld, vq[i].rs1, vq[i].rs2, vq[i].u1, vq[i].u2,
             vq[i].rd, vq[i].wr, vq[i].mr, vq[i].fl);
      #2;
      chk($sformatf("vec%0d_stall", i), int'(stall),        vq[i].e_stall);
      chk($sformatf("vec%0d_forwA", i), int'(forwA),        vq[i].e_fa);
      chk($sformatf("vec%0d_forwB", i), int'(forwB),        vq[i].e_fb);
      chk($sformatf("vec%0d_sc", i),    int'(stall_cycles), vq[i].e_sc);
      chk($sformatf("vec%0d_fe", i),    int'(forw_events),  vq[i].e_fe);
      model_check();
      tick();
    end

    // asynchronous reset in the middle of a forwarding-off stall
    pulse_reset();
    set_in(1, 1, 1, 2, 1, 1, 5, 1, 0, 0); #2; model_check(); tick();
    set_in(1, 1, 5, 3, 1, 1, 6, 1, 0, 0); #2; model_check(); tick();
    set_in(0, 1, 1, 2, 1, 1, 7, 1, 0, 0); #2; model_check(); tick();
    set_in(0, 1, 7, 0, 1, 1, 8, 1, 0, 0); #2;
    chk("midrst_pre_stall", int'(stall), 1);
    chk("midrst_pre_fe", int'(forw_events), 1);
    tick();
    #2;
    chk("midrst_pre_stall2", int'(stall), 1);
    chk("midrst_pre_sc", int'(stall_cycles), 1);
    rst = 1'b1;
    #1;
    chk("midrst_stall", int'(stall), 0);
    chk("midrst_forwA", int'(forwA), 0);
    chk("midrst_forwB", int'(forwB), 0);
    chk("midrst_sc",    int'(stall_cycles), 0);
    chk("midrst_fe",    int'(forw_events), 0);
    rst = 1'b0;
    model_reset();
    #1;
    model_check();
    tick();

    // saturation of stall_cycles: 2 stalls per producer/consumer pair, forwarding off
    pulse_reset();
    for (int k = 0; k < 20; k++) begin
      set_in(0, 1, 1, 2, 1, 1, 5, 1, 0, 0); #2; model_check(); tick();
      for (int j = 0; j < 3; j++) begin
        set_in(0, 1, 5, 0, 1, 1, 6, 1, 0, 0); #2; model_check(); tick();
      end
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("sat_stall_cycles", int'(stall_cycles), MAXC);
    tick();
    #2;
    chk("sat_hold", int'(stall_cycles), MAXC);

    // random traffic against the model
    pulse_reset();
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 149) == 0) pulse_reset();
      set_in($urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0,
             int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
             $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
             int'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
             $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0);
      #2;
      model_check();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
